wb_arbiter: RTL and testbench

//  Writeback arbiter that sources the register file's two write ports (write1/wr1/wd1, write2/wr2/wd2).

---
 rtl/mips_pkg.sv | 10 +
 rtl/wb_fifo.sv | 46 ++++
 rtl/wb_arbiter.sv | 111 +++++++++++
 tb/tb_wb_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, the zero register and the writeback entry layout.
package mips_pkg;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam logic [AW-1:0] REG_ZERO = '0;
    typedef struct packed {
        logic [AW-1:0] dst;
        logic [DW-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer of MDU results with one push and up to two pops per cycle.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int AW = 5,
    parameter int W = 37,
    localparam int PW = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push_i,
    input  logic [W-1:0]        push_data_i,
    input  logic [1:0]          pop_i,
    output logic [W-1:0]        head_o,
    output logic [W-1:0]        head1_o,
    output logic [PW-1:0]       count_o,
    output logic [DEPTH-1:0]    ent_valid_o,
    output logic [DEPTH*AW-1:0] ent_dst_o
);
    localparam int IW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [IW-1:0] rd1;
    assign count_o = wr_q - rd_q;
    assign rd1 = rd_q[IW-1:0] + 1'b1;
    assign head_o = mem_q[rd_q[IW-1:0]];
    assign head1_o = mem_q[rd1];
    assign wr_d = wr_q + PW'(push_i);
    assign rd_d = rd_q + PW'(pop_i);
    // Entry i is live when its distance from the head is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [IW-1:0] off;
        assign off = IW'(i) - rd_q[IW-1:0];
        assign ent_valid_o[i] = {1'b0, off} < count_o;
        assign ent_dst_o[i*AW +: AW] = mem_q[i][W-1 -: AW];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) mem_q[wr_q[IW-1:0]] <= push_data_i;
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges two in-order pipes and buffered MDU results onto two register-file
// write ports, resolving same-destination conflicts so the younger write wins.
module wb_arbiter
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW = mips_pkg::DW,
    parameter int AW = mips_pkg::AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            p1_valid,
    input  logic [AW-1:0]   p1_dst,
    input  logic [DW-1:0]   p1_data,
    input  logic            p2_valid,
    input  logic [AW-1:0]   p2_dst,
    input  logic [DW-1:0]   p2_data,
    input  logic            mdu_valid,
    output logic            mdu_ready,
    input  logic [AW-1:0]   mdu_dst,
    input  logic [DW-1:0]   mdu_data,
    output logic            write1,
    output logic [AW-1:0]   wr1,
    output logic [DW-1:0]   wd1,
    output logic            write2,
    output logic [AW-1:0]   wr2,
    output logic [DW-1:0]   wd2,
    output logic [2**AW-1:0] pend_mask
);
    localparam int W = AW + DW;
    localparam int PW = $clog2(DEPTH) + 1;
    logic [W-1:0]        head, head1, src1, src2;
    logic [PW-1:0]       count;
    logic [DEPTH-1:0]    ent_valid;
    logic [DEPTH*AW-1:0] ent_dst;
    logic                p1_w, p2_w, has1, has2, f1, f2, en1, en2, same;
    logic [1:0]          pops;
    logic                write1_q, write1_d, write2_q, write2_d;
    logic [AW-1:0]       wr1_q, wr1_d, wr2_q, wr2_d;
    logic [DW-1:0]       wd1_q, wd1_d, wd2_q, wd2_d;

    wb_fifo #(.DEPTH(DEPTH), .AW(AW), .W(W)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (mdu_valid && mdu_ready),
        .push_data_i ({mdu_dst, mdu_data}),
        .pop_i       (pops),
        .head_o      (head),
        .head1_o     (head1),
        .count_o     (count),
        .ent_valid_o (ent_valid),
        .ent_dst_o   (ent_dst)
    );

    assign mdu_ready = !reset && (count < PW'(DEPTH));
    assign p1_w = p1_valid && (p1_dst != REG_ZERO[AW-1:0]);
    assign p2_w = p2_valid && (p2_dst != REG_ZERO[AW-1:0]);
    assign has1 = count != '0;
    assign has2 = count > PW'(1);
    // A free port takes the oldest entry not already claimed by port 1.
    assign f1 = !p1_w && has1;
    assign f2 = !p2_w && (p1_w ? has1 : has2);
    assign pops = {1'b0, f1} + {1'b0, f2};
    assign src1 = p1_w ? {p1_dst, p1_data} : head;
    assign src2 = p2_w ? {p2_dst, p2_data} : (p1_w ? head : head1);

    always_comb begin
        en1 = (p1_w || f1) && (src1[W-1 -: AW] != REG_ZERO[AW-1:0]);
        en2 = (p2_w || f2) && (src2[W-1 -: AW] != REG_ZERO[AW-1:0]);
        same = en1 && en2 && (src1[W-1 -: AW] == src2[W-1 -: AW]);
        // Pipe results are younger than queued MDU results; otherwise port 2 is younger.
        write1_d = en1 && !(same && !(!f1 && f2));
        write2_d = en2 && !(same && !f1 && f2);
        wr1_d = src1[W-1 -: AW];
        wd1_d = src1[DW-1:0];
        wr2_d = src2[W-1 -: AW];
        wd2_d = src2[DW-1:0];
    end

    always_comb begin
        pend_mask = '0;
        for (int k = 0; k < DEPTH; k++)
            if (ent_valid[k]) pend_mask[ent_dst[k*AW +: AW]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write1_q <= 1'b0;
            write2_q <= 1'b0;
            wr1_q <= '0;
            wd1_q <= '0;
            wr2_q <= '0;
            wd2_q <= '0;
        end else begin
            write1_q <= write1_d;
            write2_q <= write2_d;
            wr1_q <= wr1_d;
            wd1_q <= wd1_d;
            wr2_q <= wr2_d;
            wd2_q <= wd2_d;
        end
    end

    // Writes launched before reset must not reach the register file during reset.
    assign write1 = write1_q && !reset;
    assign write2 = write2_q && !reset;
    assign wr1 = wr1_q;
    assign wd1 = wd1_q;
    assign wr2 = wr2_q;
    assign wd2 = wd2_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench with a queue-based reference of the MDU buffer.
module tb_wb_arbiter;
    localparam int DEPTH = 4;
    typedef struct packed {
        logic [4:0]  dst;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p1_valid = 1'b0, p2_valid = 1'b0, mdu_valid = 1'b0;
    logic [4:0]  p1_dst = '0, p2_dst = '0, mdu_dst = '0;
    logic [31:0] p1_data = '0, p2_data = '0, mdu_data = '0;
    logic        mdu_ready, write1, write2;
    logic [4:0]  wr1, wr2;
    logic [31:0] wd1, wd2, pend_mask;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .p1_valid(p1_valid), .p1_dst(p1_dst), .p1_data(p1_data),
        .p2_valid(p2_valid), .p2_dst(p2_dst), .p2_data(p2_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_dst(mdu_dst), .mdu_data(mdu_data),
        .write1(write1), .wr1(wr1), .wd1(wd1),
        .write2(write2), .wr2(wr2), .wd2(wd2),
        .pend_mask(pend_mask)
    );

    int          n_vec = 0, n_err = 0;
    ent_t        mq[$];
    logic [75:0] sb[$];

    task automatic check(input string tag, input logic [75:0] got, input logic [75:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (mq[i]) m[mq[i].dst] = 1'b1;
        return m;
    endfunction

    function automatic logic [75:0] obs();
        return {write1, write1 ? wr1 : 5'd0, write1 ? wd1 : 32'd0,
                write2, write2 ? wr2 : 5'd0, write2 ? wd2 : 32'd0};
    endfunction

    task automatic step(input logic v1, input logic [4:0] d1, input logic [31:0] x1,
                        input logic v2, input logic [4:0] d2, input logic [31:0] x2,
                        input logic mv, input logic [4:0] md, input logic [31:0] mx);
        ent_t s1, s2;
        logic h1, h2, q1, q2, e1, e2, w1, w2, rdy;
        int   np;
        p1_valid = v1; p1_dst = d1; p1_data = x1;
        p2_valid = v2; p2_dst = d2; p2_data = x2;
        mdu_valid = mv; mdu_dst = md; mdu_data = mx;
        rdy = mq.size() < DEPTH;
        check("mdu_ready", {75'd0, mdu_ready}, {75'd0, rdy});
        check("pend_mask", {44'd0, pend_mask}, {44'd0, model_mask()});
        np = 0; h1 = 0; h2 = 0; q1 = 0; q2 = 0; s1 = '0; s2 = '0;
        w1 = v1 && d1 != 0;
        w2 = v2 && d2 != 0;
        if (w1) begin s1 = {d1, x1}; h1 = 1; end
        else if (np < mq.size()) begin s1 = mq[np]; h1 = 1; q1 = 1; np++; end
        if (w2) begin s2 = {d2, x2}; h2 = 1; end
        else if (np < mq.size()) begin s2 = mq[np]; h2 = 1; q2 = 1; np++; end
        e1 = h1 && s1.dst != 0;
        e2 = h2 && s2.dst != 0;
        if (e1 && e2 && s1.dst == s2.dst) begin
            if (!q1 && q2) e2 = 0;
            else e1 = 0;
        end
        sb.push_back({e1, e1 ? s1.dst : 5'd0, e1 ? s1.data : 32'd0,
                      e2, e2 ? s2.dst : 5'd0, e2 ? s2.data : 32'd0});
        repeat (np) void'(mq.pop_front());
        if (mv && rdy) mq.push_back({md, mx});
        @(posedge clk);
        #1;
        check("wb_ports", obs(), sb.pop_front());
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic busy_push(input logic [4:0] md, input logic [31:0] mx);
        step(1, 1, 32'h100, 1, 2, 32'h200, 1, md, mx);
    endtask

    task automatic do_reset();
        reset = 1; p1_valid = 0; p2_valid = 0; mdu_valid = 0;
        #1;
        check("rst_ready", {75'd0, mdu_ready}, 76'd0);
        check("rst_cycle_write", {74'd0, write1, write2}, 76'd0);
        @(posedge clk);
        #1;
        mq.delete();
        sb.delete();
        check("rst_pend", {44'd0, pend_mask}, 76'd0);
        check("rst_next_write", {74'd0, write1, write2}, 76'd0);
        reset = 0;
        #1;
        check("rel_ready", {75'd0, mdu_ready}, 76'd1);
    endtask

    initial begin
        do_reset();
        // both pipes write
        step(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0);
        check("t1_ports", {write1, wr1, wd1, write2, wr2, wd2},
              {1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22});
        // same destination on both pipes
        step(1, 5, 32'hA, 1, 5, 32'hB, 0, 0, 0);
        check("t2_write1", {75'd0, write1}, 76'd0);
        check("t2_port2", {38'd0, write2, wr2, wd2}, {38'd0, 1'b1, 5'd5, 32'hB});
        // fill the buffer then drain two per cycle
        for (int i = 0; i < 4; i++) busy_push(5'(10 + i), 32'hA0 + i);
        check("t3_ready_full", {75'd0, mdu_ready}, 76'd0);
        check("t3_pend_bits", 76'($countones(pend_mask)), 76'd4);
        idle();
        check("t3_first_pair", {wr1, wd1, wr2, wd2}, {5'd10, 32'hA0, 5'd11, 32'hA1});
        idle();
        check("t3_second_pair", {wr1, wd1, wr2, wd2}, {5'd12, 32'hA2, 5'd13, 32'hA3});
        // popped entry loses to a pipe write to the same register
        busy_push(7, 32'h1);
        step(1, 7, 32'h2, 0, 0, 0, 0, 0, 0);
        check("t4_port1", {38'd0, write1, wr1, wd1}, {38'd0, 1'b1, 5'd7, 32'h2});
        check("t4_write2", {75'd0, write2}, 76'd0);
        check("t4_pend7", {75'd0, pend_mask[7]}, 76'd0);
        // p1 to r0 frees port 1 for the buffer head
        busy_push(9, 32'h33);
        step(1, 0, 32'hDEAD, 1, 4, 32'h44, 0, 0, 0);
        check("t5_port1", {38'd0, write1, wr1, wd1}, {38'd0, 1'b1, 5'd9, 32'h33});
        // reset with entries queued
        for (int i = 0; i < 3; i++) busy_push(5'(20 + i), 32'hC0 + i);
        check("t6_pend_before", {44'd0, pend_mask}, {44'd0, 32'h0070_0000});
        do_reset();
        // random traffic over a small register range to provoke conflicts
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)), $urandom);
        repeat (4) idle();
        check("drain_pend", {44'd0, pend_mask}, 76'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
